// File: rtl/clock_step_controller_if.sv
// Command channel of the clock step controller: a valid/ready handshake
// carrying a 2-bit opcode and a burst length. The debug front end or bench
// drives the master side; the controller is the slave.
interface clock_step_controller_if #(
    parameter int COUNT_W = 16
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [COUNT_W-1:0] cmd_count;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_count,
        output cmd_ready
    );
endinterface

// File: rtl/clock_step_controller.sv
// Run/halt/step sequencer for the processor clock. Converts the free-running
// clock into a registered clock-enable (cpu_en) for the core, under control of
// HALT / RUN / STEP / BURST commands on a valid/ready channel.
//
// Optional breakpoint support is compiled in with the macro
// CLOCK_STEP_BREAKPOINT_EN; it adds bp_enable / bp_addr inputs and the
// bp_hit output. Without the macro the controller has no breakpoint logic.
module clock_step_controller #(
    parameter int COUNT_W = 16,
    parameter int PC_W    = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    clock_step_controller_if.slave  cmd,
    input  logic [PC_W-1:0]         pc,
`ifdef CLOCK_STEP_BREAKPOINT_EN
    input  logic                    bp_enable,
    input  logic [PC_W-1:0]         bp_addr,
    output logic                    bp_hit,
`endif
    output logic                    cpu_en,
    output logic                    halted,
    output logic                    cmd_drop,
    output logic [31:0]             cycle_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_HALT  = 2'b00,
        OP_RUN   = 2'b01,
        OP_STEP  = 2'b10,
        OP_BURST = 2'b11
    } op_e;

    state_e             state;
    state_e             state_next;
    logic [COUNT_W-1:0] remaining;
    logic [COUNT_W-1:0] remaining_next;
    logic               drop_next;
    logic               fire;
    op_e                op;
    logic               bp_match;

    // The controller can always take a command except while held in reset.
    assign cmd.cmd_ready = ~reset;
    assign fire          = cmd.cmd_valid && cmd.cmd_ready;
    assign op            = op_e'(cmd.cmd_op);

`ifdef CLOCK_STEP_BREAKPOINT_EN
    // High from the second enabled cycle after leaving IDLE onwards, so a
    // RUN issued while sitting on the breakpoint PC executes it once and
    // moves past it instead of stopping immediately.
    logic armed;

    assign bp_match = (state != ST_IDLE) && armed && bp_enable && (pc == bp_addr);

    // Breakpoint arming and the one-cycle hit pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            armed  <= 1'b0;
            bp_hit <= 1'b0;
        end else begin
            armed  <= (state != ST_IDLE);
            bp_hit <= bp_match;
        end
    end
`else
    // The PC only feeds the breakpoint comparator; without it the input is
    // kept for a stable port list and deliberately left unused.
    logic pc_unused;
    assign pc_unused = ^pc;
    assign bp_match  = 1'b0;
`endif

    // Next-state decode: command handling per state, burst countdown, and
    // breakpoint stop.
    always_comb begin
        // NOTE: every output of this block is given a default before the
        // case so that no path leaves one unassigned and infers a latch.
        state_next     = state;
        remaining_next = remaining;
        drop_next      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (fire) begin
                    case (op)
                        OP_RUN: begin
                            state_next = ST_RUN;
                        end
                        OP_STEP: begin
                            state_next     = ST_BURST;
                            remaining_next = COUNT_W'(1);
                        end
                        OP_BURST: begin
                            // A zero-length burst is accepted silently.
                            if (cmd.cmd_count != '0) begin
                                state_next     = ST_BURST;
                                remaining_next = cmd.cmd_count;
                            end
                        end
                        default: begin
                            // HALT while already halted does nothing.
                        end
                    endcase
                end
            end

            ST_RUN: begin
                if (fire) begin
                    if (op == OP_HALT) begin
                        state_next = ST_IDLE;
                    end else begin
                        drop_next = 1'b1;
                    end
                end
            end

            ST_BURST: begin
                // Every cycle spent in BURST is an enabled cycle.
                remaining_next = remaining - COUNT_W'(1);
                if (remaining == COUNT_W'(1)) begin
                    state_next = ST_IDLE;
                end
                // Commands are judged against BURST even on the final
                // cycle, so only HALT is honoured here.
                if (fire) begin
                    if (op == OP_HALT) begin
                        state_next = ST_IDLE;
                    end else begin
                        drop_next = 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A breakpoint stops the core after the matching cycle executes.
        if (bp_match) begin
            state_next = ST_IDLE;
        end

        // The down-counter is only meaningful inside a burst.
        if (state_next == ST_IDLE) begin
            remaining_next = '0;
        end
    end

    // State register and the registered outputs derived from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            cpu_en    <= 1'b0;
            halted    <= 1'b1;
            cmd_drop  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register here take
            // its value from the same pre-edge snapshot, independent of
            // statement order.
            state     <= state_next;
            remaining <= remaining_next;
            cpu_en    <= (state_next != ST_IDLE);
            halted    <= (state_next == ST_IDLE);
            cmd_drop  <= drop_next;
        end
    end

    // Count of enabled cycles since reset; wraps naturally at 2^32.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (cpu_en) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

endmodule
